cardinal_input_channel: RTL
===========================

CARDINAL_INPUT_CHANNEL -- requirements
Module: cardinal_input_channel

Interface
REQ-001 SHALL: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: polarity  input  1  global even/odd phase (0 even, 1 odd); toggles every cycle after reset.
REQ-004 SHALL: si  input  1  upstream send valid.
REQ-005 SHALL: di  input  64  upstream packet.
REQ-006 SHALL: ri  output  1  ready to upstream.
REQ-007 SHALL: fwd_so  output  1  forward-port send valid.
REQ-008 SHALL: fwd_ro  input  1  forward-port ready.
REQ-009 SHALL: fwd_do  output  64  forward-port packet.
REQ-010 SHALL: ej_so  output  1  eject (local PE/NIC) send valid.
REQ-011 SHALL: ej_ro  input  1  eject-port ready.
REQ-012 SHALL: ej_do  output  64  eject-port packet.

Function
REQ-013 SHALL: packet fields: [63] VC, [62] direction, [61:56] reserved, [55:48] hop, [47:32] source, [31:0] payload.
REQ-014 SHALL: two 64-bit buffers, buf[0] (even VC) and buf[1] (odd VC), each with a full flag.
REQ-015 SHALL: input side uses buf[polarity]; output side drains buf[~polarity] in the same cycle.
REQ-016 SHALL: ri = ~full[polarity] combinationally; ri forced 0 while reset is high.
REQ-017 SHALL: si && ri at rising edge -> di captured into buf[polarity]; full[polarity] set next cycle.
REQ-018 SHALL: si while ri=0 -> no capture, buffer unchanged; upstream holds per handshake.
REQ-019 SHALL: route decision on buf[~polarity]: hop==8'h00 -> eject; hop!=0 -> forward.
REQ-020 SHALL: fwd_so = full[~polarity] && hop!=0 && fwd_ro; ej_so = full[~polarity] && hop==0 && ej_ro (combinational).
REQ-021 SHALL: fwd_do = buffered packet with hop field shifted right one bit, all other bits unchanged; ej_do = buffered packet unmodified.
REQ-022 SHALL: fwd_do/ej_do driven 64'h0 when the corresponding so is low.
REQ-023 SHALL: at most one of fwd_so/ej_so high in any cycle.
REQ-024 SHALL: asserted so -> full[~polarity] cleared at next edge (single-cycle transfer, zero added latency beyond buffering).
REQ-025 SHALL: target ro low -> packet held in buffer, no so, retried next cycle that VC is on output side.
REQ-026 SHALL: minimum latency di->so = 1 cycle (captured on phase p, drained on phase ~p next cycle).
REQ-027 SHALL: fill and drain touch different buffers; simultaneous capture and send in one cycle are both honoured.
REQ-028 SHALL: packet bit 63 not checked against polarity; buffer selection by polarity only.

Reset
REQ-029 SHALL: reset high at edge -> full[0]=full[1]=0, buffers 64'h0, all counters 0.
REQ-030 SHALL: during/after reset, ri=0 while reset high; fwd_so=ej_so=0, fwd_do=ej_do=64'h0.
REQ-031 SHALL: reset mid-transfer discards buffered packets; no so asserted in the cycle after reset deasserts.

Configuration
REQ-032 SHALL: macro CARDINAL_IC_STATS_EN, when defined, adds outputs rx_cnt, fwd_cnt, ej_cnt (16 bits each).
REQ-033 SHALL: counters increment on accepted input / fwd_so / ej_so respectively, saturate at 16'hFFFF, clear on reset.
REQ-034 SHALL: without CARDINAL_IC_STATS_EN the ports and counters are absent; behaviour otherwise identical.

Verification
REQ-035 SHALL: reset 5 cycles -> ri=0, fwd_so=ej_so=0, fwd_do=ej_do=0 throughout reset.
REQ-036 SHALL: polarity=0, si=1, di=64'h0000_0000_0000_0001 (hop 0), ej_ro=1 -> ej_so=1 next cycle with ej_do=64'h0000_0000_0000_0001.
REQ-037 SHALL: di with hop=8'h04, fwd_ro=1 -> fwd_so=1 next cycle, fwd_do hop field 8'h02, other bits equal.
REQ-038 SHALL: fwd_ro=0 for 4 cycles on buffered hop=8'h01 packet -> ri low on that phase, no fwd_so; fwd_ro=1 -> sent, hop 8'h00.
REQ-039 SHALL: back-to-back si=1 every cycle, both ro=1 -> ri stays 1, one packet out per cycle, order preserved.
REQ-040 SHALL: with CARDINAL_IC_STATS_EN, 3 ejected + 2 forwarded packets -> rx_cnt=5, ej_cnt=3, fwd_cnt=2; reset -> all 0.

Source files
------------

// File: rtl/cardinal_input_channel.sv
`default_nettype none
// ============================================================================
//  Module   : cardinal_input_channel
//  Purpose  : Two-buffer (even/odd VC) input channel for a ring-style router.
//             On each cycle the upstream side fills buf[polarity] while the
//             output side drains buf[~polarity]. A drained packet goes to the
//             eject port when its hop field is zero. Otherwise it goes to the
//             forward port with the hop field shifted right one bit.
//
//  Ports    : clk       - single clock, rising-edge active
//             reset     - synchronous, active-high reset
//             polarity  - global even/odd phase, toggles every cycle
//             si/ri/di  - upstream valid / ready / 64-bit packet
//             fwd_so/fwd_ro/fwd_do - forward port valid / ready / packet
//             ej_so/ej_ro/ej_do    - eject port valid / ready / packet
//             rx_cnt/fwd_cnt/ej_cnt - 16-bit saturating statistics
//                                     (CARDINAL_IC_STATS_EN only)
//
//  Config   : `define CARDINAL_IC_STATS_EN to add the statistics counters.
//
//  Revision : 1.0  initial release
// ============================================================================
module cardinal_input_channel (
  input  logic        clk,
  input  logic        reset,
  input  logic        polarity,
  input  logic        si,
  input  logic [63:0] di,
  output logic        ri,
  output logic        fwd_so,
  input  logic        fwd_ro,
  output logic [63:0] fwd_do,
  output logic        ej_so,
  input  logic        ej_ro,
  output logic [63:0] ej_do
`ifdef CARDINAL_IC_STATS_EN
  ,
  output logic [15:0] rx_cnt,
  output logic [15:0] fwd_cnt,
  output logic [15:0] ej_cnt
`endif
);

  logic [63:0] buf_q [2];
  logic [63:0] buf_d [2];
  logic [1:0]  full_q;
  logic [1:0]  full_d;

  logic        out_sel;
  logic [63:0] out_pkt;
  logic [7:0]  out_hop;
  logic        accept;

  always_comb begin
    out_sel = ~polarity;
    out_pkt = buf_q[out_sel];
    out_hop = out_pkt[55:48];

    // Gating with reset keeps all handshakes quiet during the reset cycle.
    // Without it, a buffer left full from before reset could still drive so.
    ri     = ~reset & ~full_q[polarity];
    fwd_so = ~reset & full_q[out_sel] & (out_hop != 8'h00) & fwd_ro;
    ej_so  = ~reset & full_q[out_sel] & (out_hop == 8'h00) & ej_ro;
    accept = si & ri;

    fwd_do = fwd_so ? {out_pkt[63:56], 1'b0, out_hop[7:1], out_pkt[47:0]} : 64'h0;
    ej_do  = ej_so ? out_pkt : 64'h0;

    buf_d  = buf_q;
    full_d = full_q;
    // Fill and drain always address opposite buffers, so both can happen
    // in the same cycle without conflict.
    if (accept) begin
      buf_d[polarity]  = di;
      full_d[polarity] = 1'b1;
    end
    if (fwd_so || ej_so) begin
      full_d[out_sel] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q[0] <= 64'h0;
      buf_q[1] <= 64'h0;
      full_q   <= 2'b00;
    end else begin
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
      full_q   <= full_d;
    end
  end

`ifdef CARDINAL_IC_STATS_EN
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] fwd_cnt_q, fwd_cnt_d;
  logic [15:0] ej_cnt_q, ej_cnt_d;

  always_comb begin
    rx_cnt_d  = rx_cnt_q;
    fwd_cnt_d = fwd_cnt_q;
    ej_cnt_d  = ej_cnt_q;
    if (accept && (rx_cnt_q != 16'hFFFF)) begin
      rx_cnt_d = rx_cnt_q + 16'd1;
    end
    if (fwd_so && (fwd_cnt_q != 16'hFFFF)) begin
      fwd_cnt_d = fwd_cnt_q + 16'd1;
    end
    if (ej_so && (ej_cnt_q != 16'hFFFF)) begin
      ej_cnt_d = ej_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cnt_q  <= 16'h0;
      fwd_cnt_q <= 16'h0;
      ej_cnt_q  <= 16'h0;
    end else begin
      rx_cnt_q  <= rx_cnt_d;
      fwd_cnt_q <= fwd_cnt_d;
      ej_cnt_q  <= ej_cnt_d;
    end
  end

  assign rx_cnt  = rx_cnt_q;
  assign fwd_cnt = fwd_cnt_q;
  assign ej_cnt  = ej_cnt_q;
`endif

endmodule
`default_nettype wire
